// File: rtl/mathlogic_pkg.sv
// Shared definitions for the mathlogic tier: widths, FSM encoding, constants.
package mathlogic_pkg;

  localparam int unsigned WIDTH     = 32;
  localparam int unsigned DIV_STEPS = 32;
  localparam int unsigned CNT_W     = 6;

  localparam logic [WIDTH-1:0] INT_MIN = 32'h8000_0000;
  localparam logic [WIDTH-1:0] NEG_ONE = 32'hFFFF_FFFF;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } div_state_e;

  // Two's complement negate when neg is set; |INT_MIN| stays 0x80000000 as unsigned.
  function automatic logic [WIDTH-1:0] neg_if(input logic neg, input logic [WIDTH-1:0] x);
    return neg ? (~x + WIDTH'(1)) : x;
  endfunction

endpackage

// File: rtl/div_step.sv
// One restoring-division iteration: shift {rem, quo} left, trial-subtract the divisor.
module div_step
  import mathlogic_pkg::*;
(
  input  logic [WIDTH-1:0] rem_i,
  input  logic [WIDTH-1:0] quo_i,
  input  logic [WIDTH-1:0] divisor_i,
  output logic [WIDTH-1:0] rem_o,
  output logic [WIDTH-1:0] quo_o
);

  logic [WIDTH-1:0] shifted_lo;
  logic [WIDTH:0]   trial;

  // Shifted partial remainder is 33 bits wide; its top bit is rem_i's MSB.
  assign shifted_lo = {rem_i[WIDTH-2:0], quo_i[WIDTH-1]};
  assign trial      = {rem_i[WIDTH-1], shifted_lo} - {1'b0, divisor_i};

  // Keep the difference only when it did not go negative.
  assign rem_o = trial[WIDTH] ? shifted_lo : trial[WIDTH-1:0];
  assign quo_o = {quo_i[WIDTH-2:0], ~trial[WIDTH]};

endmodule

// File: rtl/div32_seq.sv
// Sequential 32-bit signed divider: magnitude restoring division plus sign fix-up.
module div32_seq
  import mathlogic_pkg::*;
(
  input  logic             clock,
  input  logic             reset_n,
  input  logic             ctrl_DIV,
  input  logic [WIDTH-1:0] data_operandA,
  input  logic [WIDTH-1:0] data_operandB,
  output logic [WIDTH-1:0] data_result,
  output logic [WIDTH-1:0] data_remainder,
  output logic             data_exception,
  output logic             data_resultRDY,
  output logic             busy
);

  div_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic [WIDTH-1:0] quo_q, quo_d;
  logic [WIDTH-1:0] dvs_q, dvs_d;
  logic             qneg_q, qneg_d;
  logic             rneg_q, rneg_d;
  logic             zero_q, zero_d;
  logic             ovf_q, ovf_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic [WIDTH-1:0] remainder_q, remainder_d;
  logic             exc_q, exc_d;
  logic             rdy_q, rdy_d;
  logic             busy_q, busy_d;
  logic [WIDTH-1:0] step_rem, step_quo;

  div_step u_step (
    .rem_i     (rem_q),
    .quo_i     (quo_q),
    .divisor_i (dvs_q),
    .rem_o     (step_rem),
    .quo_o     (step_quo)
  );

  // State and datapath registers; reset clears everything including outputs.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      rem_q       <= '0;
      quo_q       <= '0;
      dvs_q       <= '0;
      qneg_q      <= 1'b0;
      rneg_q      <= 1'b0;
      zero_q      <= 1'b0;
      ovf_q       <= 1'b0;
      result_q    <= '0;
      remainder_q <= '0;
      exc_q       <= 1'b0;
      rdy_q       <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      rem_q       <= rem_d;
      quo_q       <= quo_d;
      dvs_q       <= dvs_d;
      qneg_q      <= qneg_d;
      rneg_q      <= rneg_d;
      zero_q      <= zero_d;
      ovf_q       <= ovf_d;
      result_q    <= result_d;
      remainder_q <= remainder_d;
      exc_q       <= exc_d;
      rdy_q       <= rdy_d;
      busy_q      <= busy_d;
    end
  end

  // Next-state logic; a start pulse restarts from any state and drops a pending result.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    rem_d       = rem_q;
    quo_d       = quo_q;
    dvs_d       = dvs_q;
    qneg_d      = qneg_q;
    rneg_d      = rneg_q;
    zero_d      = zero_q;
    ovf_d       = ovf_q;
    result_d    = result_q;
    remainder_d = remainder_q;
    exc_d       = 1'b0;
    rdy_d       = 1'b0;

    if (ctrl_DIV) begin
      // Dividend magnitude enters the quotient register and shifts into rem.
      quo_d   = neg_if(data_operandA[WIDTH-1], data_operandA);
      dvs_d   = neg_if(data_operandB[WIDTH-1], data_operandB);
      rem_d   = '0;
      cnt_d   = '0;
      qneg_d  = data_operandA[WIDTH-1] ^ data_operandB[WIDTH-1];
      rneg_d  = data_operandA[WIDTH-1];
      zero_d  = (data_operandB == '0);
      ovf_d   = (data_operandA == INT_MIN) && (data_operandB == NEG_ONE);
      state_d = (data_operandB == '0) ? DONE : RUN;
    end else begin
      case (state_q)
        RUN: begin
          rem_d = step_rem;
          quo_d = step_quo;
          cnt_d = cnt_q + CNT_W'(1);
          if (cnt_q == CNT_W'(DIV_STEPS - 1)) begin
            state_d = DONE;
          end
        end
        DONE: begin
          state_d = IDLE;
          rdy_d   = 1'b1;
          if (zero_q) begin
            // quo still holds |A|, so restoring A's sign reproduces A.
            result_d    = '0;
            remainder_d = neg_if(rneg_q, quo_q);
            exc_d       = 1'b1;
          end else if (ovf_q) begin
            result_d    = INT_MIN;
            remainder_d = '0;
            exc_d       = 1'b1;
          end else begin
            result_d    = neg_if(qneg_q, quo_q);
            remainder_d = neg_if(rneg_q, rem_q);
          end
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end

    busy_d = (state_d != IDLE) || rdy_d;
  end

  assign data_result    = result_q;
  assign data_remainder = remainder_q;
  assign data_exception = exc_q;
  assign data_resultRDY = rdy_q;
  assign busy           = busy_q;

endmodule

// File: doc/div32_seq.md
# div32_seq

Sequential 32-bit signed integer divider for the processor's multdiv path, in the mathlogic tier alongside the bitwise and adder units. It accepts a one-cycle start pulse with dividend and divisor, runs a 32-iteration restoring (shift/subtract) division, and returns the quotient, remainder, exception flag and a one-cycle ready pulse. The pipeline stalls on the divider while it is busy.

## Interface
- WIDTH, 32, operand/result width; only 32 is supported.
- clock  input  1  rising-edge clock.
- reset_n  input  1  asynchronous, active-low reset.
- ctrl_DIV  input  1  start pulse; operands sampled on the same edge.
- data_operandA  input  32  dividend, two's complement.
- data_operandB  input  32  divisor, two's complement.
- data_result  output  32  quotient.
- data_remainder  output  32  remainder.
- data_exception  output  1  divide-by-zero or overflow; valid while data_resultRDY=1.
- data_resultRDY  output  1  one-cycle pulse; outputs valid.
- busy  output  1  division in progress (RUN or DONE).

## Operation
- Reset (async, reset_n=0): state IDLE, count=0, data_result=0, data_remainder=0, data_exception=0, data_resultRDY=0, busy=0.
- States: IDLE, RUN, DONE.
- IDLE + ctrl_DIV:
  - Latch |A| and |B|, plus the quotient sign (A[31]^B[31]) and the remainder sign (A[31]).
  - If B==0, go to DONE with the zero flag set. Otherwise go to RUN with count=0.
- RUN, one step per cycle:
  - Shift {rem, quo} left by 1.
  - Compute trial = rem − |B| at 33 bits.
  - If trial is non-negative, rem=trial and quo[0]=1.
  - count increments. After the step at count=31, go to DONE.
- DONE, one cycle, registered on the exit edge:
  - data_result is the sign-corrected quo, truncated toward zero.
  - data_remainder is rem negated if the remainder sign is set.
  - data_resultRDY=1 and data_exception are set. Next state is IDLE.
- Divide by zero: data_result=0, data_remainder=A, data_exception=1.
- Overflow (A=0x80000000, B=0xFFFFFFFF): data_result=0x80000000, data_remainder=0, data_exception=1. Detected at start; the iterations still run.
- |A|, |B| are 32-bit unsigned magnitudes, so |0x80000000| = 0x80000000 is correct.
- ctrl_DIV while busy aborts the current operation. New operands are latched and the FSM restarts as from IDLE; no ready pulse is produced for the aborted operation.
- data_result and data_remainder hold their last values until the next completion.
- data_exception is cleared on the cycle after the ready pulse.

## Timing
- Edge E0 samples ctrl_DIV. Edges E1..E32 perform the 32 steps.
- Registered outputs update on edge E33. data_resultRDY is high for exactly the cycle following E33: latency 33 cycles.
- Divide by zero: the outputs update on E1, and data_resultRDY is high for the cycle following E1.
- busy is high from the cycle after E0 until data_resultRDY deasserts.
- ctrl_DIV coincident with the data_resultRDY cycle is accepted as a new start. The completing result is still presented.
- reset_n asserted mid-operation forces IDLE immediately and clears all outputs. There is no ready pulse.

## Structure
- Shared package mathlogic_pkg:
  - State encoding: IDLE=2'd0, RUN=2'd1, DONE=2'd2.
  - DIV_STEPS=32, CNT_W=6.
  - Constants INT_MIN=32'h80000000 and NEG_ONE=32'hFFFFFFFF.
- One natural sub-module: div_step, purely combinational. Inputs: rem, quo, divisor. Outputs: next rem and next quo.
- Keep the FSM, counter and sign fix-up in div32_seq.

## Test plan
- 100 / 7 → result 14, remainder 2, exception 0, data_resultRDY exactly 33 cycles after ctrl_DIV.
- −100 / 7 → result −14 (0xFFFFFFF2), remainder −2. Also 100 / −7 → result −14, remainder 2.
- 5 / 0 → result 0, remainder 5, exception 1, data_resultRDY on the cycle after E1.
- 0x80000000 / 0xFFFFFFFF → result 0x80000000, remainder 0, exception 1. Also 0x80000000 / 1 → result 0x80000000, remainder 0, exception 0.
- Start 1000 / 3, then pulse ctrl_DIV with 50 / 5 at cycle 10:
  - Exactly one data_resultRDY, 33 cycles after the second start: result 10, remainder 0.
  - A separate run pulses reset_n at cycle 20 → outputs cleared, no data_resultRDY.
- Random signed operands (≥1000 pairs, nonzero divisor) checked against a reference model:
  - Quotient truncates toward zero.
  - result*B + remainder == A.
  - The remainder's sign matches A.
